// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and defaults for the register-file access controller.
// Holds the command opcode encoding, FSM state type and size defaults.
package regfile_access_ctrl_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic [1:0] {
    OP_READ2 = 2'b00,
    OP_WRITE = 2'b01,
    OP_COPY  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    RESP
  } state_e;

  // READ2 and COPY both consume the second address field; WRITE ignores it.
  function automatic logic op_uses_b(input op_e op);
    return (op == OP_READ2) || (op == OP_COPY);
  endfunction

endpackage

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the register file: READ2 / WRITE / COPY
// commands in, registered register-file port set out, one response per command.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              rf_en,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2
);

  state_e              state_reg, state_next;
  op_e                 op_reg;
  logic [ADDR_W-1:0]   addr_b_reg;
  logic                cmd_ready_reg;
  logic                rsp_valid_reg, rsp_err_reg;
  logic [DATA_W-1:0]   rsp_data1_reg, rsp_data2_reg;
  logic [ADDR_W-1:0]   rf_read_reg1_reg, rf_read_reg2_reg, rf_write_reg_reg;
  logic [DATA_W-1:0]   rf_write_data_reg;
  logic                rf_en_reg, rf_reg_write_reg;

  op_e  cmd_op_e;
  logic accept;
  logic cmd_err;

  assign cmd_op_e = op_e'(cmd_op);
  assign accept   = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;
  assign cmd_err  = (cmd_op_e == OP_RSVD)
                  || (cmd_addr_a >= ADDR_W'(DEPTH))
                  || (op_uses_b(cmd_op_e) && (cmd_addr_b >= ADDR_W'(DEPTH)));

  always_ff @(posedge Clk) begin
    if (Rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (cmd_err)                    state_next = RESP;
          else if (cmd_op_e == OP_WRITE)  state_next = WR_ISSUE;
          else                            state_next = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_next = RD_CAPTURE;
      RD_CAPTURE: state_next = (op_reg == OP_COPY) ? WR_ISSUE : RESP;
      WR_ISSUE:   state_next = RESP;
      RESP:       if (rsp_valid_reg && rsp_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Port-set and response registers; write strobes follow the next state so
  // they are high exactly while the FSM sits in WR_ISSUE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_reg            <= OP_READ2;
      addr_b_reg        <= '0;
      cmd_ready_reg     <= 1'b1;
      rsp_valid_reg     <= 1'b0;
      rsp_err_reg       <= 1'b0;
      rsp_data1_reg     <= '0;
      rsp_data2_reg     <= '0;
      rf_read_reg1_reg  <= '0;
      rf_read_reg2_reg  <= '0;
      rf_write_reg_reg  <= '0;
      rf_write_data_reg <= '0;
      rf_en_reg         <= 1'b0;
      rf_reg_write_reg  <= 1'b0;
    end else begin
      cmd_ready_reg    <= (state_next == IDLE);
      rf_en_reg        <= (state_next == WR_ISSUE);
      rf_reg_write_reg <= (state_next == WR_ISSUE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg     <= cmd_op_e;
            addr_b_reg <= cmd_addr_b;
            if (cmd_err) begin
              rsp_data1_reg <= '0;
              rsp_data2_reg <= '0;
              rsp_err_reg   <= 1'b1;
            end else if (cmd_op_e == OP_WRITE) begin
              rf_write_reg_reg  <= cmd_addr_a;
              rf_write_data_reg <= cmd_wdata;
            end else begin
              rf_read_reg1_reg <= cmd_addr_a;
              if (cmd_op_e == OP_READ2) rf_read_reg2_reg <= cmd_addr_b;
            end
          end
        end
        RD_CAPTURE: begin
          if (op_reg == OP_COPY) begin
            rf_write_reg_reg  <= addr_b_reg;
            rf_write_data_reg <= rf_read_data1;
          end else begin
            rsp_data1_reg <= rf_read_data1;
            rsp_data2_reg <= rf_read_data2;
            rsp_err_reg   <= 1'b0;
          end
        end
        WR_ISSUE: begin
          rsp_data1_reg <= rf_write_data_reg;
          rsp_data2_reg <= '0;
          rsp_err_reg   <= 1'b0;
        end
        RESP: begin
          rsp_valid_reg <= !(rsp_valid_reg && rsp_ready);
        end
        default: ;
      endcase
    end
  end

  // Gating with Rst keeps the controller closed for the whole reset window.
  assign cmd_ready     = cmd_ready_reg && !Rst;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_err       = rsp_err_reg;
  assign rsp_data1     = rsp_data1_reg;
  assign rsp_data2     = rsp_data2_reg;
  assign rf_read_reg1  = rf_read_reg1_reg;
  assign rf_read_reg2  = rf_read_reg2_reg;
  assign rf_write_reg  = rf_write_reg_reg;
  assign rf_write_data = rf_write_data_reg;
  assign rf_en         = rf_en_reg;
  assign rf_reg_write  = rf_reg_write_reg;

endmodule
